// File: rtl/dual_rail_decoder.sv
// dual_rail_decoder: four-phase RTZ dual-rail receiver with completion detection and a one-entry output buffer.
// Latency: codeword stable on the pins from edge k gives dout_valid/ack after edge k+STABLE-1 (same for spacer->ack low).
// Backpressure: a full buffer withholds capture and ack; capture happens on the first edge the buffer drains.
module dual_rail_decoder #(
  parameter int WIDTH  = 8,   // dual-rail pairs, index 7..0 = b4,a3,b3,a2,b2,a1,b1,a0
  parameter int STABLE = 2,   // identical samples needed before acting, 1..15
  parameter int CNT_W  = 8    // width of word_cnt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  output logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err_illegal,
  output logic [CNT_W-1:0] word_cnt
);

  // Run-length counter only needs to reach STABLE, which is at most 15.
  localparam int              RUN_W   = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE);

  typedef enum logic [1:0] {
    RESYNC  = 2'd0,  // waiting for a clean spacer after reset
    COLLECT = 2'd1,  // spacer seen, waiting for a complete stable codeword
    HOLD    = 2'd2,  // word captured and acked, waiting for return to spacer
    ERR     = 2'd3   // illegal pair seen, waiting for a clean spacer
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_1;
  logic [WIDTH-1:0] prev_0;
  logic [RUN_W-1:0] run_cnt;

  logic             same;
  logic [RUN_W-1:0] run_nxt;
  logic             stable;
  logic             any_illegal;
  logic             all_spacer;
  logic             all_complete;
  logic             stable_spacer;
  logic             stable_word;
  logic             buf_free;
  logic             drain;

  // Classify the current sample and work out whether it has been steady long enough.
  always_comb begin
    same          = (din_1 == prev_1) && (din_0 == prev_0);
    run_nxt       = RUN_W'(1);
    if (same) begin
      run_nxt = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + RUN_W'(1);
    end
    // The sample being taken at this edge counts, hence STABLE-1 edges of latency.
    stable        = (run_nxt >= RUN_MAX);
    any_illegal   = |(din_1 & din_0);
    all_spacer    = ~|(din_1 | din_0);
    all_complete  = &(din_1 ^ din_0);
    stable_spacer = stable && all_spacer;
    stable_word   = stable && all_complete;
    // A word being drained this edge frees the slot for a capture on the same edge.
    buf_free      = !dout_valid || dout_ready;
    drain         = dout_valid && dout_ready;
  end

  // Track the previous sample and how many consecutive edges it has been held.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_1  <= '0;
      prev_0  <= '0;
      run_cnt <= '0;
    end else begin
      prev_1  <= din_1;
      prev_0  <= din_0;
      run_cnt <= run_nxt;
    end
  end

  // Handshake FSM with registered ack, output buffer, error pulse and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESYNC;
      ack         <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      err_illegal <= 1'b0;
      word_cnt    <= '0;
    end else begin
      err_illegal <= 1'b0;
      // Consumer handshake empties the buffer; a capture below overrides this.
      if (drain) begin
        dout_valid <= 1'b0;
      end
      if (any_illegal) begin
        // Illegal pairs win in every state; ack keeps its value so the sender is not confused.
        if (state != ERR) begin
          err_illegal <= 1'b1;
        end
        state <= ERR;
      end else begin
        case (state)
          RESYNC: begin
            if (stable_spacer) begin
              state <= COLLECT;
            end
          end
          COLLECT: begin
            // With the buffer full we simply wait here without acking.
            if (stable_word && buf_free) begin
              dout       <= din_1;
              dout_valid <= 1'b1;
              word_cnt   <= word_cnt + CNT_W'(1);
              ack        <= 1'b1;
              state      <= HOLD;
            end
          end
          HOLD, ERR: begin
            // Data wiggles before the spacer are ignored; only a clean spacer re-arms.
            if (stable_spacer) begin
              ack   <= 1'b0;
              state <= COLLECT;
            end
          end
          default: begin
            state <= RESYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_rail_decoder.sv
// tb_dual_rail_decoder: directed stimulus for dual_rail_decoder, checked by a protocol-level model every cycle
// plus literal expectations at the key points of each scenario.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_dual_rail_decoder;
  localparam int WIDTH  = 8;
  localparam int STABLE = 2;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din_0 = '0;
  logic [WIDTH-1:0] din_1 = '0;
  logic             ack;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             err_illegal;
  logic [CNT_W-1:0] word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dual_rail_decoder #(.WIDTH(WIDTH), .STABLE(STABLE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_0      (din_0),
    .din_1      (din_1),
    .ack        (ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err_illegal(err_illegal),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- protocol model ----------------
  // need_sp: the receiver must see a clean spacer before it will take another word
  // (after reset, after an ack, after an illegal code). in_err: an illegal code is outstanding.
  logic             m_ack, m_vld, m_err;
  logic [WIDTH-1:0] m_dout;
  logic [CNT_W-1:0] m_cnt;
  logic [2*WIDTH-1:0] last, cur;
  int  run;
  bit  need_sp, in_err, model_on = 0;
  bit  ill, sp, cw, cap, steady;

  always @(posedge clk) begin
    if (rst) begin
      m_ack = 0; m_vld = 0; m_err = 0; m_dout = '0; m_cnt = '0;
      run = 0; last = '0; need_sp = 1; in_err = 0; model_on = 1;
    end else begin
      cur = {din_1, din_0};
      if (run == 0 || cur != last) run = 1;
      else if (run < STABLE) run = run + 1;
      last   = cur;
      steady = (run >= STABLE);
      ill    = (din_1 & din_0) != '0;
      sp     = (din_1 | din_0) == '0;
      cw     = (din_1 ^ din_0) == {WIDTH{1'b1}};
      cap    = 0;
      m_err  = 0;
      if (ill) begin
        m_err   = !in_err;
        in_err  = 1;
        need_sp = 1;
      end else if (steady && sp && need_sp) begin
        need_sp = 0;
        in_err  = 0;
        m_ack   = 0;
      end else if (steady && cw && !need_sp && (!m_vld || dout_ready)) begin
        cap = 1;
      end
      if (cap) begin
        m_dout  = din_1;
        m_vld   = 1;
        m_cnt   = m_cnt + 1'b1;
        m_ack   = 1;
        need_sp = 1;
      end else if (m_vld && dout_ready) begin
        m_vld = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      chk("mdl_ack", 32'(ack), 32'(m_ack));
      chk("mdl_dout_valid", 32'(dout_valid), 32'(m_vld));
      chk("mdl_dout", 32'(dout), 32'(m_dout));
      chk("mdl_err_illegal", 32'(err_illegal), 32'(m_err));
      chk("mdl_word_cnt", 32'(word_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0);
    din_1 = d1;
    din_0 = d0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0);
    cycles(1);
    rst = 1'b0;
    cycles(3);
  endtask

  logic [WIDTH-1:0] tgt, b1, b0, w;

  initial begin
    // 1: reset, spacer, A5 with consumer ready
    cycles(2);
    rst = 1'b0;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_cnt", 32'(word_cnt), 0);
    cycles(3);
    dout_ready = 1'b1;
    drive(8'hA5, 8'h5A);
    cycles(1);
    chk("t1_valid_edge0", 32'(dout_valid), 0);
    cycles(1);
    chk("t1_dout", 32'(dout), 32'h A5);
    chk("t1_valid", 32'(dout_valid), 1);
    chk("t1_ack", 32'(ack), 1);
    chk("t1_cnt", 32'(word_cnt), 1);
    drive('0, '0);
    cycles(1);
    chk("t1_ack_sp_edge0", 32'(ack), 1);
    cycles(1);
    chk("t1_ack_low", 32'(ack), 0);

    // 2: backpressure
    do_reset();
    dout_ready = 1'b0;
    drive(8'h3C, 8'hC3);
    cycles(2);
    chk("t2_dout_3c", 32'(dout), 32'h3C);
    chk("t2_ack_3c", 32'(ack), 1);
    drive('0, '0);
    cycles(2);
    chk("t2_ack_low", 32'(ack), 0);
    chk("t2_valid_held", 32'(dout_valid), 1);
    drive(8'hC3, 8'h3C);
    cycles(4);
    chk("t2_bp_ack", 32'(ack), 0);
    chk("t2_bp_dout", 32'(dout), 32'h3C);
    chk("t2_bp_cnt", 32'(word_cnt), 1);
    dout_ready = 1'b1;
    cycles(1);
    chk("t2_cap_dout", 32'(dout), 32'hC3);
    chk("t2_cap_valid", 32'(dout_valid), 1);
    chk("t2_cap_ack", 32'(ack), 1);
    chk("t2_cap_cnt", 32'(word_cnt), 2);
    dout_ready = 1'b0;
    drive('0, '0);
    cycles(2);
    dout_ready = 1'b1;
    cycles(1);
    chk("t2_drained", 32'(dout_valid), 0);

    // 3: glitchy arrival, one pair at a time, then one change after completion
    tgt = 8'h96;
    b1  = '0;
    b0  = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      b1[i] = tgt[i];
      b0[i] = ~tgt[i];
      drive(b1, b0);
      cycles(2);
    end
    chk("t3_partial_cnt", 32'(word_cnt), 2);
    chk("t3_partial_valid", 32'(dout_valid), 0);
    b1[WIDTH-1] = tgt[WIDTH-1];
    b0[WIDTH-1] = ~tgt[WIDTH-1];
    drive(b1, b0);
    cycles(1);
    chk("t3_first_complete", 32'(word_cnt), 2);
    drive(8'h69, 8'h96);
    cycles(1);
    chk("t3_changed_edge0", 32'(word_cnt), 2);
    cycles(1);
    chk("t3_cap_cnt", 32'(word_cnt), 3);
    chk("t3_cap_dout", 32'(dout), 32'h69);
    cycles(3);
    chk("t3_single_inc", 32'(word_cnt), 3);
    drive('0, '0);
    cycles(2);

    // 4: illegal pair 3 during COLLECT
    drive(8'h08, 8'h08);
    cycles(1);
    chk("t4_err_pulse", 32'(err_illegal), 1);
    chk("t4_ack", 32'(ack), 0);
    chk("t4_valid", 32'(dout_valid), 0);
    cycles(1);
    chk("t4_err_one_cycle", 32'(err_illegal), 0);
    cycles(2);
    chk("t4_err_no_repulse", 32'(err_illegal), 0);
    drive('0, '0);
    cycles(2);
    dout_ready = 1'b0;
    drive(8'h0F, 8'hF0);
    cycles(2);
    chk("t4_dout_0f", 32'(dout), 32'h0F);
    chk("t4_valid_0f", 32'(dout_valid), 1);
    chk("t4_ack_0f", 32'(ack), 1);
    chk("t4_cnt", 32'(word_cnt), 4);

    // 5: reset while in HOLD with a buffered word
    rst = 1'b1;
    cycles(1);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_dout", 32'(dout), 0);
    chk("t5_valid", 32'(dout_valid), 0);
    chk("t5_err", 32'(err_illegal), 0);
    chk("t5_cnt", 32'(word_cnt), 0);
    rst = 1'b0;
    cycles(4);
    chk("t5_resync_valid", 32'(dout_valid), 0);
    chk("t5_resync_cnt", 32'(word_cnt), 0);
    chk("t5_resync_ack", 32'(ack), 0);

    // 6: 256 word/spacer cycles, counter wraps to zero
    do_reset();
    dout_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      w = 8'(k * 37 + 11);
      drive(w, ~w);
      cycles(2);
      chk("t6_dout", 32'(dout), 32'(w));
      chk("t6_cnt", 32'(word_cnt), 32'((k + 1) % 256));
      drive('0, '0);
      cycles(2);
    end
    chk("t6_wrap", 32'(word_cnt), 0);
    chk("t6_ack_low", 32'(ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_rail_decoder.md
Name: dual_rail_decoder

Overview:
- Receiving end of the dual-rail (0-rail/1-rail) bus driven by the first stage of the modular adder/subtractor.
- Samples the pairs (b4, a3, b3, a2, b2, a1, b1, a0) each clock and runs four-phase return-to-zero completion detection.
- Captures each complete, stable codeword as a binary word in a one-entry output buffer with valid/ready.
- Acknowledges the sender, counts received words and flags illegal codes.

Parameters:
- WIDTH, 8, number of dual-rail pairs. Index 7..0 = b4, a3, b3, a2, b2, a1, b1, a0.
- STABLE, 2, consecutive identical samples required before capturing a codeword or accepting a spacer. Legal range 1..15.
- CNT_W, 8, width of word_cnt.

Ports:
- clk, in, 1, single clock. All logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- din_0, in, WIDTH, 0-rails.
- din_1, in, WIDTH, 1-rails.
- ack, out, 1, four-phase acknowledge to the sender.
- dout, out, WIDTH, decoded word; dout[i] = din_1[i] of the captured codeword.
- dout_valid, out, 1, output buffer holds a word.
- dout_ready, in, 1, consumer accepts dout when dout_valid and dout_ready are both high.
- err_illegal, out, 1, one-cycle pulse when an illegal pair is detected.
- word_cnt, out, CNT_W, number of captured words, modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - ack=0, dout=0, dout_valid=0, err_illegal=0, word_cnt=0.
  - Stability counter cleared; state=RESYNC.
  - Reset mid-transfer discards any partial word and any buffered word.
- Pair classification per bit:
  - 00 = spacer bit.
  - 01 = logic 0 (din_1=0, din_0=1).
  - 10 = logic 1 (din_1=1, din_0=0).
  - 11 = illegal.
  - Complete = no pair is 00 and none is 11. Spacer = every pair is 00.
- Stability: a counter tracks consecutive edges with identical {din_1, din_0}. It restarts on any change and saturates at STABLE.
- States:
  - RESYNC: ack=0. Wait for a stable spacer, then go to COLLECT.
  - COLLECT: ack=0. A stable complete codeword with a free buffer leads to capture. Capture means: dout <= din_1, dout_valid <= 1, word_cnt += 1, ack <= 1, go to HOLD.
  - If the codeword is stable but the buffer is full, remain in COLLECT with no ack. This is backpressure. Capture happens on the first edge at which the buffer frees, including an edge where the old word is being drained that same cycle.
  - HOLD: ack=1. A stable spacer sets ack <= 0 and returns to COLLECT. Data changes before the spacer are ignored.
  - ERR: entered from any state on an illegal pair. err_illegal=1 for exactly the entry cycle. No capture occurs and ack is held at its current value. A stable spacer drops ack to 0 and moves to COLLECT.
  - Repeated illegal samples while in ERR do not re-pulse err_illegal.
- Latency: a codeword held on the pins from before edge k, with the buffer free, gives dout_valid=1 and ack=1 after edge k+STABLE-1.
  - For STABLE=2: pins valid before edge 0, outputs high after edge 1.
  - Spacer-to-ack-low follows the same STABLE-1 rule.
- Buffer:
  - dout_valid clears on handshake (dout_valid & dout_ready) unless a capture occurs on the same edge. In that case the new word replaces the old and dout_valid stays 1.
  - dout is stable while dout_valid=1 and dout_ready=0.
- word_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- Partial codewords (some pairs still 00) never capture, regardless of how long they are held.

Test Plan:
1. Reset, then spacer for 3 cycles, then codeword din_1=8'hA5, din_0=8'h5A held with dout_ready=1.
   - Response: dout=8'hA5, dout_valid=1 and ack=1 after edge 1 of the word; word_cnt=1.
   - Spacer held for 2 cycles: ack=0 after edge 1 of the spacer.
2. dout_ready=0. Send word 8'h3C through a full handshake, then word 8'hC3.
   - Response: 8'hC3 is not acked and dout stays 8'h3C.
   - Raising dout_ready for 1 cycle: 8'hC3 captured on that edge, dout_valid stays 1, word_cnt=2.
3. Glitchy arrival: bits become valid one per cycle, and the word changes once after it is complete.
   - Response: no capture until the final value is stable for 2 samples; exactly one increment of word_cnt.
4. Pair 3 driven 11 during COLLECT.
   - Response: err_illegal high for 1 cycle only, no dout_valid, ack=0.
   - After a stable spacer, the next word 8'h0F is captured normally.
5. Assert rst while in HOLD with dout_valid=1.
   - Response: after the edge, all outputs are 0.
   - A complete word applied without a preceding spacer is not captured (state is RESYNC).
6. 256 word/spacer cycles with CNT_W=8.
   - Response: word_cnt returns to 0 and dout matches every sent word in order.
